// File: rtl/ice_main_osc_stab.sv
// ICE-side main-oscillator stabilization monitor: counts synchronized CPUTMCLK edges,
// reports OSTC/MSTAB, drives the CPUMCLK source select and flags oscillation loss.
module ice_main_osc_stab #(
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 8,
  parameter int TMO_CYC     = 200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CPUTMCLK,
  input  logic       OSCSEL,
  input  logic       MSTOP,
  input  logic [2:0] OSTS,
  output logic [7:0] OSTC,
  output logic       MSTAB,
  output logic       CPUMCLK_SEL,
  output logic       OSC_FAIL,
  output logic       OSC_LOST
);

  localparam logic [17:0]      CNT_MAX = 18'h3FFFF;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);

  typedef enum logic [1:0] {IDLE, COUNT, STABLE, FAIL} state_t;

  function automatic logic [17:0] thr(input logic [2:0] n);
    case (n)
      3'd0:    thr = 18'h00100;
      3'd1:    thr = 18'h00200;
      3'd2:    thr = 18'h00400;
      3'd3:    thr = 18'h00800;
      3'd4:    thr = 18'h02000;
      3'd5:    thr = 18'h08000;
      3'd6:    thr = 18'h20000;
      default: thr = 18'h3FFFF;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_p;
  state_t                 state, state_nx;
  logic [17:0]            cnt_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [2:0]             osts_q;
  logic [7:0]             ostc_q, ostc_nx;
  logic                   fail_q, lost_q;
  logic                   exit_req, tmo_hit, thr_hit, clr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], CPUTMCLK};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_p   = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign exit_req = ~OSCSEL | MSTOP;
  // An edge in the same cycle as the limit rescues the oscillator.
  assign tmo_hit  = (tmo_q == TMO_LIM) & ~edge_p;
  assign thr_hit  = cnt_q >= thr(osts_q);
  assign clr      = (state == IDLE) | (state_nx == IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!exit_req) state_nx = COUNT;
      COUNT:   if (exit_req) state_nx = IDLE;
               else if (tmo_hit) state_nx = FAIL;
               else if (thr_hit) state_nx = STABLE;
      STABLE:  if (exit_req) state_nx = IDLE;
               else if (tmo_hit) state_nx = FAIL;
      FAIL:    if (exit_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ostc_nx = '0;
    for (int n = 0; n < 8; n++) ostc_nx[n] = cnt_q >= thr(3'(n));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      cnt_q  <= '0;
      tmo_q  <= '0;
      osts_q <= '0;
      ostc_q <= '0;
      fail_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state  <= state_nx;
      fail_q <= (state_nx == FAIL) && (state != FAIL);
      lost_q <= (state_nx == FAIL);
      ostc_q <= clr ? 8'h00 : ostc_nx;
      if (state == IDLE && state_nx == COUNT) osts_q <= OSTS;
      if (clr) begin
        cnt_q <= '0;
        tmo_q <= '0;
      end else if (state == COUNT || state == STABLE) begin
        if (edge_p && cnt_q != CNT_MAX) cnt_q <= cnt_q + 18'd1;
        if (edge_p) tmo_q <= '0;
        else if (tmo_q != TMO_LIM) tmo_q <= tmo_q + TMO_W'(1);
      end
    end
  end

  assign OSTC        = ostc_q;
  assign MSTAB       = (state == STABLE);
  assign CPUMCLK_SEL = (state == STABLE);
  assign OSC_FAIL    = fail_q;
  assign OSC_LOST    = lost_q;

endmodule
